// File: rtl/nios2sys_fb_scanout.sv
// Generic word FIFO: the writer is credited through count and must never push when count == DEPTH.
// Latency: a pushed word is visible on rd_dat the cycle after the push edge.
// Backpressure: rd_rdy low holds the head entry; there is no write-side ready.
module nios2sys_fb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   rd_vld,
    output logic [WIDTH-1:0]       rd_dat,
    input  logic                   rd_rdy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld & rd_rdy;

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_vld, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Frame-buffer scan-out: walks memory words from BASE_ADDR and streams them as 8-bit pixels, byte 0 first.
// Latency: first pixel appears two cycles after its read strobe; 1 pixel/clk sustained thereafter.
// Backpressure: m_ready low holds the pixel; reads stop while FIFO entries plus reads in flight reach FIFO_DEPTH.
module nios2sys_fb_scanout #(
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 19200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] mem_address,
    output logic        mem_chipselect,
    input  logic [31:0] mem_readdata,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eof,
    output logic        busy,
    output logic        underrun,
    input  logic        clear_underrun
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] ADDR_BASE = 16'(BASE_ADDR);
    localparam logic [15:0] LAST_PTR  = 16'(NUM_WORDS - 1);
    localparam logic [15:0] PTR_ONE   = 16'd1;
    localparam logic [CW:0] DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [1:0]  IDX_ONE   = 2'd1;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [31:0] dat;
    } word_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [15:0]   ptr, ptr_nxt;
    logic          issue;
    logic          last_word;
    logic          cs_sof, cs_eof;
    logic          pend_vld, pend_sof, pend_eof;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   outstanding;
    logic          room;
    word_t         wr_word;
    word_t         head_word;
    logic          head_vld;
    logic [7:0]    head_byte;
    logic [1:0]    idx;
    logic          xfer;
    logic          pop;
    logic          in_frame;
    logic          ur_set;

    assign wr_word = '{sof: pend_sof, eof: pend_eof, dat: mem_readdata};

    nios2sys_fb_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (pend_vld),
        .wr_dat (wr_word),
        .rd_vld (head_vld),
        .rd_dat (head_word),
        .rd_rdy (pop),
        .count  (fifo_count)
    );

    // Both the strobe cycle and the data-return cycle hold a FIFO slot in reserve.
    assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, mem_chipselect} + {{CW{1'b0}}, pend_vld};
    assign room        = (outstanding < DEPTH_W);
    assign last_word   = (ptr == LAST_PTR);

    assign head_byte = head_word.dat[{idx, 3'b000} +: 8];
    assign m_valid   = head_vld;
    assign m_data    = head_vld ? head_byte : 8'h00;
    assign m_sof     = head_vld & head_word.sof & (idx == 2'd0);
    assign m_eof     = head_vld & head_word.eof & (idx == 2'd3);
    assign xfer      = head_vld & m_ready;
    assign pop       = xfer & (idx == 2'd3);
    assign busy      = (state != ST_IDLE);
    assign ur_set    = busy & m_ready & ~head_vld & in_frame;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                    ptr_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (room) begin
                    issue = 1'b1;
                    if (last_word) begin
                        ptr_nxt = '0;
                        if (!enable) state_nxt = ST_DRAIN;
                    end else begin
                        ptr_nxt = ptr + PTR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that retires the final pixel so busy drops right after it.
                if (!mem_chipselect && !pend_vld &&
                    ((fifo_count == '0) || ((fifo_count == CNT_ONE) && pop)))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            cs_sof         <= 1'b0;
            cs_eof         <= 1'b0;
            pend_vld       <= 1'b0;
            pend_sof       <= 1'b0;
            pend_eof       <= 1'b0;
            idx            <= '0;
            in_frame       <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            mem_chipselect <= issue;
            if (issue) begin
                mem_address <= ADDR_BASE + ptr;
                cs_sof      <= (ptr == '0);
                cs_eof      <= last_word;
            end
            pend_vld <= mem_chipselect;
            pend_sof <= cs_sof;
            pend_eof <= cs_eof;
            if (xfer) begin
                idx      <= idx + IDX_ONE;
                in_frame <= ~m_eof;
            end
            underrun <= ur_set | (underrun & ~clear_underrun);
        end
    end
endmodule

// File: tb/tb_nios2sys_fb_scanout.sv
// Directed bench for the frame-buffer scan-out: two instances, one at base 0 and one offset at base 100.
// Latency: all checks are sampled 1 time unit after the rising edge.
// Backpressure: m_ready is driven directly by the bench, including a random 30% stall phase.
module tb_nios2sys_fb_scanout;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_enable, a_cs, a_valid, a_ready, a_sof, a_eof, a_busy, a_underrun, a_clear;
    logic [15:0] a_addr;
    logic [31:0] a_rdata;
    logic [7:0]  a_data;
    logic        b_reset, b_enable, b_cs, b_valid, b_ready, b_sof, b_eof, b_busy, b_underrun, b_clear;
    logic [15:0] b_addr;
    logic [31:0] b_rdata;
    logic [7:0]  b_data;

    nios2sys_fb_scanout #(.BASE_ADDR(0), .NUM_WORDS(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .mem_address(a_addr), .mem_chipselect(a_cs),
        .mem_readdata(a_rdata), .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready), .m_sof(a_sof),
        .m_eof(a_eof), .busy(a_busy), .underrun(a_underrun), .clear_underrun(a_clear));

    nios2sys_fb_scanout #(.BASE_ADDR(100), .NUM_WORDS(3), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .mem_address(b_addr), .mem_chipselect(b_cs),
        .mem_readdata(b_rdata), .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready), .m_sof(b_sof),
        .m_eof(b_eof), .busy(b_busy), .underrun(b_underrun), .clear_underrun(b_clear));

    // Memory models return data only in the cycle after a strobe.
    always @(posedge clk) a_rdata <= a_cs ? (32'hA0B0C0D0 + {16'h0, a_addr}) : 32'hDEADBEEF;
    always @(posedge clk) b_rdata <= b_cs ? {16'hBEEF, b_addr} : 32'hDEADBEEF;

    int total = 0, bad = 0, cyc = 0, strobes = 0, xfers = 0, cs_after = 0;
    bit held = 0, watch_idle = 0, b_got_first = 0;
    logic [9:0] held_v;
    logic [7:0] rec_dat[$];
    bit rec_sof[$], rec_eof[$];
    int rec_cyc[$];
    logic [15:0] b_addr_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gold_a(input int n);
        logic [31:0] w;
        w = 32'hA0B0C0D0 + 32'((n / 4) % 4);
        return w[8*(n%4) +: 8];
    endfunction

    // Observe the current cycle, then advance to 1 unit after the next rising edge.
    task automatic step();
        if (held && a_valid) chk("stall_hold", {22'h0, a_data, a_sof, a_eof}, {22'h0, held_v});
        held   = a_valid && !a_ready;
        held_v = {a_data, a_sof, a_eof};
        if (a_cs) begin
            strobes++;
            chk("outstanding_le_depth", ((strobes - xfers / 4) <= 4) ? 1 : 0, 1);
            if (watch_idle) cs_after++;
        end
        if (a_valid && a_ready) begin
            rec_dat.push_back(a_data);
            rec_sof.push_back(a_sof);
            rec_eof.push_back(a_eof);
            rec_cyc.push_back(cyc);
            xfers++;
        end
        if (b_cs) begin
            b_addr_q.push_back(b_addr);
            chk("b_addr_range", (b_addr >= 16'd100 && b_addr <= 16'd102) ? 1 : 0, 1);
        end
        if (b_valid && b_ready && !b_got_first) begin
            chk("b_first_pix", {23'h0, b_data, b_sof}, {23'h0, 8'h64, 1'b1});
            b_got_first = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_rec();
        rec_dat.delete(); rec_sof.delete(); rec_eof.delete(); rec_cyc.delete();
        strobes = 0; xfers = 0; held = 0;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_addr"}, {16'h0, a_addr}, 0);
        chk({pfx, "_cs"}, {31'h0, a_cs}, 0);
        chk({pfx, "_valid"}, {31'h0, a_valid}, 0);
        chk({pfx, "_data"}, {24'h0, a_data}, 0);
        chk({pfx, "_sof_eof"}, {30'h0, a_sof, a_eof}, 0);
        chk({pfx, "_busy"}, {31'h0, a_busy}, 0);
        chk({pfx, "_underrun"}, {31'h0, a_underrun}, 0);
    endtask

    task automatic check_pixels(input string tag);
        for (int i = 0; i < rec_dat.size(); i++)
            chk(tag, {22'h0, rec_dat[i], rec_sof[i], rec_eof[i]},
                {22'h0, gold_a(i), (i % 16 == 0), (i % 16 == 15)});
    endtask

    initial begin
        a_reset = 1; a_enable = 0; a_ready = 0; a_clear = 0;
        b_reset = 1; b_enable = 0; b_ready = 0; b_clear = 0;
        step(); step();
        check_zero("rst");

        // Continuous flow: two back-to-back frames with no gaps after fill.
        b_reset = 0; b_enable = 1; b_ready = 1;
        a_reset = 0; a_enable = 1; a_ready = 1;
        clear_rec();
        for (int i = 0; i < 45; i++) step();
        chk("t1_count_ge32", (rec_dat.size() >= 32) ? 1 : 0, 1);
        for (int i = 0; i < 32 && i < rec_dat.size(); i++)
            chk("t1_pix", {22'h0, rec_dat[i], rec_sof[i], rec_eof[i]},
                {22'h0, gold_a(i), (i % 16 == 0), (i % 16 == 15)});
        for (int i = 1; i < 32 && i < rec_dat.size(); i++)
            chk("t1_no_gap", rec_cyc[i] - rec_cyc[i-1], 1);
        chk("t1_no_underrun", {31'h0, a_underrun}, 0);

        // Random backpressure.
        a_reset = 1; step(); a_reset = 0; clear_rec();
        for (int i = 0; i < 400; i++) begin
            a_ready = ($urandom_range(0, 99) >= 30);
            step();
        end
        a_ready = 1;
        chk("t2_progress", (rec_dat.size() >= 100) ? 1 : 0, 1);
        check_pixels("t2_pix");

        // Disable after pixel 5: the frame whose last word is issued with enable low completes.
        a_reset = 1; step(); a_reset = 0; clear_rec();
        for (int i = 0; i < 100 && rec_dat.size() < 5; i++) step();
        a_enable = 0;
        for (int i = 0; i < 300 && a_busy; i++) step();
        chk("t3_busy_low", {31'h0, a_busy}, 0);
        chk("t3_pix_count", rec_dat.size(), 32);
        if (rec_dat.size() > 0) begin
            chk("t3_busy_fall", cyc - rec_cyc[rec_cyc.size()-1], 1);
            chk("t3_last_eof", {31'h0, rec_eof[rec_eof.size()-1]}, 1);
        end
        check_pixels("t3_pix");
        watch_idle = 1; cs_after = 0;
        for (int i = 0; i < 20; i++) step();
        watch_idle = 0;
        chk("t3_no_strobe", cs_after, 0);
        chk("t3_no_more_pix", rec_dat.size(), 32);

        // Reset mid-frame while a read is in flight.
        a_reset = 1; step(); a_reset = 0; clear_rec(); a_enable = 1;
        for (int i = 0; i < 100 && !(rec_dat.size() >= 6 && a_cs); i++) step();
        chk("t4_cs_in_flight", {31'h0, a_cs}, 1);
        a_reset = 1; step(); a_reset = 0; a_enable = 0; clear_rec();
        check_zero("t4");
        step();
        chk("t4_inflight_dropped", {31'h0, a_valid}, 0);
        a_enable = 1;
        for (int i = 0; i < 50 && rec_dat.size() < 1; i++) step();
        chk("t4_got_pix", (rec_dat.size() >= 1) ? 1 : 0, 1);
        if (rec_dat.size() >= 1) chk("t4_first", {23'h0, rec_dat[0], rec_sof[0]}, {23'h0, 8'hD0, 1'b1});

        // Underrun: starve the stream mid-frame.
        for (int i = 0; i < 50 && rec_dat.size() < 3; i++) step();
        chk("t5_pre", {31'h0, a_underrun}, 0);
        force dut_a.head_vld = 1'b0;
        step();
        chk("t5_set", {31'h0, a_underrun}, 1);
        step(); step(); step();
        chk("t5_hold", {31'h0, a_underrun}, 1);
        a_clear = 1;
        step();
        chk("t5_set_wins", {31'h0, a_underrun}, 1);
        release dut_a.head_vld;
        #1;
        chk("t5_valid_back", {31'h0, a_valid}, 1);
        step();
        chk("t5_clear", {31'h0, a_underrun}, 0);
        a_clear = 0;
        step();
        chk("t5_stay_clear", {31'h0, a_underrun}, 0);

        // Offset instance: address walk wraps inside [100, 102].
        chk("b_got_first", {31'h0, b_got_first}, 1);
        chk("b_addr_count", (b_addr_q.size() >= 9) ? 1 : 0, 1);
        for (int i = 0; i < 9 && i < b_addr_q.size(); i++)
            chk("b_addr_seq", {16'h0, b_addr_q[i]}, 100 + (i % 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
